// File: rtl/kv260_led_breather_if.sv
// Control/status bundle for the breathing LED driver: run/sync requests in,
// PMOD drive and activity flag out.
interface kv260_led_breather_if #(
  parameter int N = 8
);
  logic         enable;
  logic         sync;
  logic [N-1:0] pmod;
  logic         busy;

  modport master (output enable, output sync, input pmod, input busy);
  modport slave  (input enable, input sync, output pmod, output busy);
endinterface

// File: rtl/kv260_led_breather.sv
// Triangle-envelope PWM driver for N PMOD LEDs with per-channel phase offset,
// sync realignment and a fade-out stop that finishes the current envelope.
//
// state | meaning
// IDLE  | counters held at 0, outputs off
// RUN   | envelope running, enable high
// STOP  | envelope running until phase wraps to 0, then IDLE
module kv260_led_breather #(
  parameter int N           = 8,
  parameter int PWM_BITS    = 8,
  parameter int STEP_LIMIT  = 1000,
  parameter int PHASE_SHIFT = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  kv260_led_breather_if.slave   bus
);
  localparam int PHW = PWM_BITS + 1;
  localparam int SCW = (STEP_LIMIT > 1) ? $clog2(STEP_LIMIT) : 1;
  localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [SCW-1:0]      STEP_LAST = SCW'(STEP_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [SCW-1:0]      step_cnt_q, step_cnt_d;
  logic [PHW-1:0]      phase_q, phase_d;
  logic [N-1:0]        pmod_q, pmod_d;
  logic                busy;
  logic                active, step_tick, sync_hit, phase_wrap;
  logic [PHW-1:0]      ch_phase;
  logic [PWM_BITS-1:0] duty;

  assign active    = (state_q != IDLE);
  assign step_tick = active && (step_cnt_q == STEP_LAST);
  assign sync_hit  = active && bus.sync;
  // A sync on the wrapping tick forces phase 0 itself, so it does not count as a wrap.
  assign phase_wrap = step_tick && (phase_q == '1) && !sync_hit;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable) state_d = RUN;
      RUN:     if (!bus.enable) state_d = STOP;
      STOP: begin
        if (bus.enable)      state_d = RUN;
        else if (phase_wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pwm_cnt_d  = pwm_cnt_q;
    step_cnt_d = step_cnt_q;
    phase_d    = phase_q;
    if (!active || state_d == IDLE || sync_hit) begin
      pwm_cnt_d  = '0;
      step_cnt_d = '0;
      phase_d    = '0;
    end else begin
      pwm_cnt_d  = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);
      step_cnt_d = step_tick ? '0 : step_cnt_q + SCW'(1);
      if (step_tick) phase_d = phase_q + PHW'(1);
    end
  end

  always_comb begin
    busy     = active;
    pmod_d   = '0;
    ch_phase = '0;
    duty     = '0;
    for (int i = 0; i < N; i++) begin
      ch_phase = phase_q + PHW'(i * PHASE_SHIFT);
      duty     = ch_phase[PWM_BITS] ? ~ch_phase[PWM_BITS-1:0] : ch_phase[PWM_BITS-1:0];
      pmod_d[i] = (state_q != IDLE) && (state_d != IDLE) && (duty > pwm_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      phase_q    <= '0;
      pmod_q     <= '0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      phase_q    <= phase_d;
      pmod_q     <= pmod_d;
    end
  end

  assign bus.pmod = pmod_q;
  assign bus.busy = busy;
endmodule

// File: tb/tb_kv260_led_breather.sv
// Directed bench for kv260_led_breather at N=2, W=4, STEP_LIMIT=4, PHASE_SHIFT=8.
// Expected PWM levels come from a hand-computed duty table indexed by envelope phase.
module tb_kv260_led_breather;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   cyc;

  kv260_led_breather_if #(.N(2)) bus ();

  kv260_led_breather #(
    .N(2), .PWM_BITS(4), .STEP_LIMIT(4), .PHASE_SHIFT(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int d0;
    int d1;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Cycle c of an aligned run has pwm_cnt = c mod 15 and phase = (c/4) mod 32.
  task automatic tick_chk();
    int c;
    int ph;
    int pw;
    c  = cyc;
    ph = (c / 4) % 32;
    pw = c % 15;
    tick();
    for (int k = 0; k < 7; k++) begin
      if (vecs[k].ph == ph) begin
        check($sformatf("pmod0_ph%0d_c%0d", ph, c), int'(bus.pmod[0]), int'(vecs[k].d0 > pw));
        check($sformatf("pmod1_ph%0d_c%0d", ph, c), int'(bus.pmod[1]), int'(vecs[k].d1 > pw));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    vecs[0] = '{ph: 0,  d0: 0,  d1: 8};
    vecs[1] = '{ph: 1,  d0: 1,  d1: 9};
    vecs[2] = '{ph: 5,  d0: 5,  d1: 13};
    vecs[3] = '{ph: 15, d0: 15, d1: 8};
    vecs[4] = '{ph: 16, d0: 15, d1: 7};
    vecs[5] = '{ph: 20, d0: 11, d1: 3};
    vecs[6] = '{ph: 30, d0: 1,  d1: 6};

    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.sync   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset_pmod", int'(bus.pmod), 0);
      check("reset_busy", int'(bus.busy), 0);
    end
    reset = 1'b0;
    tick();
    check("busy_after_release", int'(bus.busy), 1);
    check("pmod_first_run", int'(bus.pmod), 0);
    cyc = 0;

    // One full envelope of PWM levels against the duty table.
    while (cyc < 128) tick_chk();
    check("busy_run", int'(bus.busy), 1);

    // Sync mid-step at phase 10.
    while (cyc < 169) tick();
    check("pre_sync_phase", int'(dut.phase_q), 10);
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    check("sync_phase", int'(dut.phase_q), 0);
    check("sync_step", int'(dut.step_cnt_q), 0);
    check("sync_pwm", int'(dut.pwm_cnt_q), 0);
    cyc = 0;

    // Sync coincident with a step tick.
    while (cyc < 3) tick();
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    check("sync_tick_phase", int'(dut.phase_q), 0);
    check("sync_tick_step", int'(dut.step_cnt_q), 0);
    cyc = 0;

    // Fade out from phase 5; IDLE exactly when phase wraps 31 -> 0.
    while (cyc < 20) tick_chk();
    bus.enable = 1'b0;
    while (cyc < 128) begin
      tick_chk();
      check($sformatf("stop_busy_c%0d", cyc), int'(bus.busy), int'(cyc < 128));
    end
    check("idle_pmod", int'(bus.pmod), 0);
    check("idle_phase", int'(dut.phase_q), 0);
    for (int i = 0; i < 3; i++) tick();
    check("idle_hold_busy", int'(bus.busy), 0);
    check("idle_hold_pmod", int'(bus.pmod), 0);
    check("idle_hold_pwm", int'(dut.pwm_cnt_q), 0);

    // Restart, stop at phase 1, re-raise enable at phase 20.
    bus.enable = 1'b1;
    tick();
    check("restart_busy", int'(bus.busy), 1);
    cyc = 0;
    while (cyc < 4) tick_chk();
    bus.enable = 1'b0;
    while (cyc < 80) tick_chk();
    bus.enable = 1'b1;
    tick_chk();
    check("reraise_busy", int'(bus.busy), 1);
    check("reraise_phase", int'(dut.phase_q), 20);
    while (cyc < 130) tick_chk();
    check("rerun_past_wrap_busy", int'(bus.busy), 1);

    // Reset mid-run at phase 12.
    while (cyc < 176) tick_chk();
    check("pre_reset_phase", int'(dut.phase_q), 12);
    reset = 1'b1;
    tick();
    check("midreset_pmod", int'(bus.pmod), 0);
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_phase", int'(dut.phase_q), 0);

    // Sync while IDLE is ignored.
    reset      = 1'b0;
    bus.enable = 1'b0;
    bus.sync   = 1'b1;
    tick();
    bus.sync = 1'b0;
    check("idle_sync_busy", int'(bus.busy), 0);
    check("idle_sync_pmod", int'(bus.pmod), 0);
    check("idle_sync_phase", int'(dut.phase_q), 0);
    check("idle_sync_step", int'(dut.step_cnt_q), 0);
    tick();
    check("idle_sync_stays", int'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
